// File: rtl/mux_rr_n.sv
// ============================================================================
// mux_rr_n : N-channel valid/ready multiplexer, registered output,
//            manual select or round-robin arbitration.  Rev 1.0
// ============================================================================
`default_nettype none

module mux_rr_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_ch
);

  localparam int            NP    = 1 << SELW;
  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  ptr_next;
  logic [NP-1:0]    valid_pad;
  logic [WIDTH-1:0] ch_data [NP];
  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic [SELW:0]    idx;

  // Pad to the full select range so any sel value indexes safely and never grants.
  generate
    for (genvar i = 0; i < NP; i++) begin : g_chan
      if (i < N) begin : g_real
        assign ch_data[i]   = in_data[i*WIDTH +: WIDTH];
        assign valid_pad[i] = in_valid[i];
      end else begin : g_pad
        assign ch_data[i]   = '0;
        assign valid_pad[i] = 1'b0;
      end
    end
  endgenerate

  assign load = !out_valid || out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    if (!mode) begin
      if (({1'b0, sel} < N_EXT) && valid_pad[sel]) begin
        grant_valid = 1'b1;
        grant       = sel;
      end
    end else begin
      // Scan from the farthest offset down so the one closest to rr_ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
        idx = {1'b0, rr_ptr} + (SELW+1)'(k);
        if (idx >= N_EXT) idx = idx - N_EXT;
        if (valid_pad[idx[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant       = idx[SELW-1:0];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_ready
      assign in_ready[i] = !rst && load && grant_valid && (grant == SELW'(i));
    end
  endgenerate

  assign ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_data  <= ch_data[grant];
        out_ch    <= grant;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_n.sv
// ============================================================================
// tb_mux_rr_n : scoreboard bench for mux_rr_n (N=4 main DUT, N=3 side DUT).
// ============================================================================
`default_nettype none

module tb_mux_rr_n;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb [$];
  int    m_ptr;

  always #5 clk = ~clk;

  mux_rr_n #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_rr_n #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[23:0]), .in_valid(in_valid[2:0]),
    .in_ready(in_ready3), .mode(mode), .sel(sel), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_ch(out_ch3)
  );

  // Reference grant for the N=4 DUT
  function automatic void model_grant(output bit gv, output logic [1:0] g);
    gv = 1'b0;
    g  = 2'd0;
    if (!mode) begin
      if (in_valid[sel]) begin gv = 1'b1; g = sel; end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!gv && in_valid[j]) begin gv = 1'b1; g = 2'(j); end
      end
    end
  endfunction

  function automatic logic [3:0] exp_ready();
    bit gv;
    logic [1:0] g;
    model_grant(gv, g);
    if (rst || !((sb.size() == 0) || out_ready) || !gv) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Advance one clock and update the reference register contents.
  task automatic step();
    bit gv;
    logic [1:0] g;
    bit ld;
    beat_t b;
    model_grant(gv, g);
    ld = (sb.size() == 0) || out_ready;
    @(posedge clk);
    if (ld) begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (gv) begin
        b.data = in_data[g*8 +: 8];
        b.ch   = g;
        sb.push_back(b);
        if (mode) m_ptr = (g + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic drive(input bit m, input logic [1:0] s, input logic [3:0] v, input bit ordy);
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    logic [3:0] er;
    rst      = 1'b1;
    in_data  = 32'h44332211;
    drive(1'b0, 2'd2, 4'b1111, 1'b1);
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, out_ch} !== 11'd0) begin
      n_fail++; $display("FAIL reset_init_out: got v=%b d=%h ch=%0d want 0", out_valid, out_data, out_ch);
    end
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_init_ready: got %b want 0000", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_prestream_valid: got %b want 1", out_valid);
    end
    // Mid-stream asynchronous reset, checked before the next edge
    rst = 1'b1;
    #1;
    sb.delete();
    m_ptr = 0;
    n_checks++;
    if ({out_valid, out_data, out_ch} !== 11'd0) begin
      n_fail++; $display("FAIL reset_async_out: got v=%b d=%h ch=%0d want 0", out_valid, out_data, out_ch);
    end
    er = exp_ready();
    n_checks++;
    if (in_ready !== er) begin
      n_fail++; $display("FAIL reset_async_ready: got %b want %b", in_ready, er);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_manual();
    logic [3:0] er;
    drive(1'b0, 2'd2, 4'b1111, 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er || in_ready !== 4'b0100) begin
        n_fail++; $display("FAIL manual_ready: got %b want %b", in_ready, er);
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0) || (sb.size() != 0 && {out_data, out_ch} !== sb[0])) begin
        n_fail++; $display("FAIL manual_out: got v=%b d=%h ch=%0d want d=%h ch=%0d",
                           out_valid, out_data, out_ch, sb[0].data, sb[0].ch);
      end
      n_checks++;
      if (out_data !== 8'h33 || out_ch !== 2'd2) begin
        n_fail++; $display("FAIL manual_const: got d=%h ch=%0d want 33/2", out_data, out_ch);
      end
      step();
    end
  endtask

  task automatic test_manual_invalid();
    logic [3:0] er;
    drive(1'b0, 2'd2, 4'b1011, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++; $display("FAIL invsel_ready: got %b want %b", in_ready, er);
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0)) begin
        n_fail++; $display("FAIL invsel_valid: got %b want %b", out_valid, sb.size() != 0);
      end
      step();
    end
    // N=3 instance: sel=3 is out of range and must never grant
    drive(1'b0, 2'd3, 4'b1111, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready3 !== 3'b000) begin
        n_fail++; $display("FAIL sel_oob_ready: got %b want 000", in_ready3);
      end
      step();
      n_checks++;
      if (out_valid3 !== 1'b0) begin
        n_fail++; $display("FAIL sel_oob_valid: got %b want 0", out_valid3);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int c = 0; c < 8; c++) begin
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++; $display("FAIL rr_ready: got %b want %b", in_ready, er);
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0) || (sb.size() != 0 && {out_data, out_ch} !== sb[0])) begin
        n_fail++; $display("FAIL rr_out: got v=%b d=%h ch=%0d want d=%h ch=%0d",
                           out_valid, out_data, out_ch, sb[0].data, sb[0].ch);
      end
      step();
    end
  endtask

  task automatic test_skip_wrap();
    logic [3:0] want [3];
    logic [3:0] er;
    want[0] = 4'b1000;
    want[1] = 4'b0001;
    want[2] = 4'b1000;
    drive(1'b1, 2'd0, 4'b0001, 1'b1);
    step();
    drive(1'b1, 2'd0, 4'b1001, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er || in_ready !== want[c]) begin
        n_fail++; $display("FAIL skipwrap_ready: got %b want %b", in_ready, want[c]);
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0) || (sb.size() != 0 && {out_data, out_ch} !== sb[0])) begin
        n_fail++; $display("FAIL skipwrap_out: got v=%b d=%h ch=%0d want d=%h ch=%0d",
                           out_valid, out_data, out_ch, sb[0].data, sb[0].ch);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] er;
    drive(1'b1, 2'd0, 4'b0010, 1'b1);
    step();
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er || in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready: got %b want %b", in_ready, er);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || sb.size() != 1 || {out_data, out_ch} !== sb[0]) begin
        n_fail++; $display("FAIL bp_hold: got v=%b d=%h ch=%0d want d=22 ch=1", out_valid, out_data, out_ch);
      end
      step();
    end
    // Release: 0x22 consumed and channel 2 loaded on the same edge
    out_ready = 1'b1;
    #1;
    er = exp_ready();
    n_checks++;
    if (in_ready !== er || in_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want %b", in_ready, er);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33 || out_ch !== 2'd2 || {out_data, out_ch} !== sb[0]) begin
      n_fail++; $display("FAIL bp_release_out: got v=%b d=%h ch=%0d want d=33 ch=2", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      in_data = $urandom;
      #1;
      er = exp_ready();
      n_checks++;
      if (in_ready !== er) begin
        n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, in_ready, er);
      end
      n_checks++;
      if (out_valid !== (sb.size() != 0) || (sb.size() != 0 && {out_data, out_ch} !== sb[0])) begin
        n_fail++; $display("FAIL rand_out: cycle %0d got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d", c,
                           out_valid, out_data, out_ch, sb.size() != 0, sb[0].data, sb[0].ch);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_manual_invalid();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-input, WIDTH-bit channel multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Generalises the 2:1 mux to N channels and arbitrary width.
- Two select modes: manual (external sel) and round-robin auto-arbitration.
- Sits between several producer channels and one consumer; one beat forwarded per cycle, 1-cycle latency.

Parameters:
- WIDTH, 8, data bits per channel
- N, 4, number of input channels (2..16)
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= N

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i has a beat
- in_ready  output  N  channel i beat accepted this cycle (combinational)
- mode  input  1  0 = manual select, 1 = round-robin
- sel  input  SELW  channel index used in manual mode
- out_data  output  WIDTH  registered output beat
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  consumer accepts beat
- out_ch  output  SELW  index of channel that supplied out_data

Behaviour:
- Reset (async, on rst high, independent of clk):
  - out_data=0, out_valid=0, out_ch=0, rr_ptr=0.
  - in_ready=0 while rst is high.
  - A beat held in the register is discarded; no partial transfer survives.
- Load enable: load = !out_valid || out_ready. Combinational; no extra bubble cycles.
- Grant, combinational, evaluated every cycle:
  - Manual (mode=0): grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants.
  - Round-robin (mode=1): grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, …, wrapping N-1 -> 0. No valid input means no grant.
- in_ready[i] = load && grant_valid && grant==i. At most one bit set per cycle (one-hot or zero).
- Transfer on an input occurs when in_valid[i] && in_ready[i].
- On the clock edge with load=1:
  - If a grant exists: out_data <= channel data, out_ch <= grant, out_valid <= 1.
  - If no grant: out_valid <= 0; out_data and out_ch hold their values.
- On the clock edge with load=0 (out_valid && !out_ready): out_data, out_ch and out_valid hold. All in_ready are 0, so no input beat is lost.
- Round-robin pointer:
  - Updates only on an input transfer in mode 1: rr_ptr <= grant+1, wrapping N-1 -> 0.
  - Held in mode 0 and on cycles with no transfer.
- Latency: an input beat accepted at edge k appears on out_data after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- Mode or sel changes take effect on the next combinational grant evaluation. The registered beat is unaffected.
- Simultaneous out_ready and new grant in the same cycle: the old beat is consumed and the new beat loaded on the same edge, with no bubble.
- Input data must be stable while in_valid is high and in_ready is low. The block does not check this.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately, before the next clk edge; in_ready=0 while rst is high.
- Manual mode: N=4, WIDTH=8, mode=0, sel=2, all in_valid=1, in_data ch0..3 = 0x11/0x22/0x33/0x44, out_ready=1 -> in_ready=4'b0100 every cycle; out_data=0x33, out_ch=2 from the second cycle onward.
- Manual invalid select: sel=2, in_valid=4'b1011 -> in_ready=0; out_valid drops to 0 after one edge. With N=3 and sel=3 -> never grants.
- Round-robin fairness: mode=1, all in_valid=1, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles; each in_ready pulses once per 4 cycles.
- Round-robin skip and wrap: in_valid=4'b1001, rr_ptr=1 -> grants 3 then 0 then 3.
- Backpressure: out_ready=0 for 3 cycles with a beat 0x22 held -> out_data=0x22 stable, in_ready=0, rr_ptr unchanged. Raise out_ready -> 0x22 consumed and the next beat loaded on the same edge, no gap.
